// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the machine-level external interrupt controller.
package irq_ctrl_pkg;

    localparam int unsigned ID_W   = 5;
    localparam int unsigned ADDR_W = 8;

    localparam logic [ADDR_W-1:0] IRQ_PENDING = 8'h00;
    localparam logic [ADDR_W-1:0] IRQ_ENABLE  = 8'h04;
    localparam logic [ADDR_W-1:0] IRQ_EDGE    = 8'h08;
    localparam logic [ADDR_W-1:0] IRQ_CLAIM   = 8'h0C;

    typedef enum logic {
        IDLE      = 1'b0,
        INSERVICE = 1'b1
    } irq_state_t;

    typedef logic [ID_W-1:0] irq_id_t;

endpackage

// File: rtl/irq_src_sync.sv
// Per-source synchroniser with registered level and single-cycle rising-edge pulse.
module irq_src_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src_i,
    output logic level_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rise_q, rise_d;

    // Last stage is the synchronised level; the stage before it is one cycle
    // ahead, so comparing the two yields a rise pulse aligned with the level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
        rise_d = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
        end
    end

    assign level_sync = sync_q[SYNC_STAGES-1];
    assign rise       = rise_q;

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller: source latching, enable masking, fixed-priority
// selection and a single-outstanding claim/complete handshake over the data bus.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_SRC-1:0]  src_i,
    input  logic                bus_req,
    input  logic                bus_we,
    input  logic [ADDR_W-1:0]   bus_addr,
    input  logic [31:0]         bus_wdata,
    output logic [31:0]         bus_rdata,
    output logic                bus_rvalid,
    output logic                irq_o
);

    logic [NUM_SRC-1:0] level_sync;
    logic [NUM_SRC-1:0] rise;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_src_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk        (clk),
            .rst_n      (rst_n),
            .src_i      (src_i[g]),
            .level_sync (level_sync[g]),
            .rise       (rise[g])
        );
    end

    irq_state_t         state_q, state_d;
    irq_id_t            active_id_q, active_id_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_mode_q, edge_mode_d;
    logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
    logic               irq_q, irq_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic [NUM_SRC-1:0] pend_eff;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] win_mask;
    logic [NUM_SRC-1:0] claim_clr;
    irq_id_t            win_id;
    logic [ADDR_W-1:0]  reg_sel;
    logic               rd_en;
    logic               wr_en;

    always_comb begin
        pend_eff  = (edge_mode_q & edge_pend_q) | (~edge_mode_q & level_sync);
        eligible  = pend_eff & enable_q;
        reg_sel   = {bus_addr[ADDR_W-1:2], 2'b00};
        rd_en     = bus_req & ~bus_we;
        wr_en     = bus_req & bus_we;
        win_id    = '0;
        win_mask  = '0;
        claim_clr = '0;

        // Scan downward so the lowest index (highest priority) is the last writer.
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id      = irq_id_t'(i + 1);
                win_mask    = '0;
                win_mask[i] = 1'b1;
            end
        end

        state_d     = state_q;
        active_id_d = active_id_q;
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        rdata_d     = rdata_q;
        rvalid_d    = rd_en;

        if (rd_en) begin
            case (reg_sel)
                IRQ_PENDING: rdata_d = 32'(pend_eff);
                IRQ_ENABLE:  rdata_d = 32'(enable_q);
                IRQ_EDGE:    rdata_d = 32'(edge_mode_q);
                IRQ_CLAIM: begin
                    rdata_d = '0;
                    if (state_q == IDLE && win_id != '0) begin
                        rdata_d     = 32'(win_id);
                        active_id_d = win_id;
                        state_d     = INSERVICE;
                        claim_clr   = win_mask;
                    end
                end
                default:     rdata_d = '0;
            endcase
        end

        if (wr_en) begin
            case (reg_sel)
                IRQ_ENABLE: enable_d    = bus_wdata[NUM_SRC-1:0];
                IRQ_EDGE:   edge_mode_d = bus_wdata[NUM_SRC-1:0];
                IRQ_CLAIM: begin
                    if (state_q == INSERVICE && irq_id_t'(bus_wdata[ID_W-1:0]) == active_id_q) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end

        // A fresh edge in the claim cycle survives the claim's clear.
        edge_pend_d = (edge_pend_q & ~claim_clr) | (rise & edge_mode_q);
        if (wr_en && reg_sel == IRQ_EDGE) begin
            edge_pend_d = edge_pend_d & bus_wdata[NUM_SRC-1:0];
        end

        irq_d = (state_q == IDLE) && (|eligible);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            active_id_q <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            edge_pend_q <= '0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_id_q <= active_id_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            edge_pend_q <= edge_pend_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign irq_o      = irq_q;

    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

endmodule
